// File: rtl/spi_pkg.sv
// Shared SPI master types and counter-width helpers.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package spi_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  // One spare bit so terminal-count compares never wrap for legal parameters.
  function automatic int div_cnt_w(input int clk_div);
    return $clog2(clk_div) + 1;
  endfunction

  function automatic int bit_cnt_w(input int data_w);
    return $clog2(2 * data_w) + 1;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: half-period tick, sclk toggling, leading/trailing edge strobes.
// Latency: tick every CLK_DIV cycles while en; strobes coincide with the sclk flip.
// Backpressure: none; counter idles at zero whenever en is low.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic load,
  input  logic load_lvl,
  input  logic idle_lvl,
  input  logic toggle_en,
  output logic tick,
  output logic sclk,
  output logic lead,
  output logic trail
);

  localparam int DIV_W = div_cnt_w(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  assign tick  = en && (div_cnt == DIV_LAST);
  // An edge leaving the idle level is the leading edge of that clock period.
  assign lead  = tick && toggle_en && (sclk == idle_lvl);
  assign trail = tick && toggle_en && (sclk != idle_lvl);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else begin
      if (!en || tick) div_cnt <= '0;
      else             div_cnt <= div_cnt + DIV_W'(1);
      if (load)                   sclk <= load_lvl;
      else if (tick && toggle_en) sclk <= ~sclk;
    end
  end

endmodule

// File: rtl/spi_master_modes.sv
// Full-duplex SPI master, all four modes per transaction; SPI_LOOPBACK_EN adds a mosi->sample loopback port.
// Latency: ss_n low for (2*DATA_W+2)*CLK_DIV cycles; rx_valid pulses in the cycle IDLE is re-entered.
// Backpressure: tx_ready high only in IDLE; tx_valid is ignored while busy.
module spi_master_modes
  import spi_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              miso,
`ifdef SPI_LOOPBACK_EN
  input  logic              loopback,
`endif
  output logic              sclk,
  output logic              mosi,
  output logic              ss_n,
  output logic              busy,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data
);

  localparam int BIT_W = bit_cnt_w(DATA_W);
  localparam logic [BIT_W-1:0] HALF_LAST = BIT_W'(2 * DATA_W - 1);

  spi_state_t        state;
  spi_mode_t         mode_q;
  logic [DATA_W-1:0] tx_sh, rx_sh, sh_src, sh_next, rx_next;
  logic [BIT_W-1:0]  half_cnt;
  logic              tick, lead, trail, accept, last_half;
  logic              drive_evt, sample_evt, sin, sh_bit;

  assign accept    = tx_valid && tx_ready;
  assign last_half = (half_cnt == HALF_LAST);

`ifdef SPI_LOOPBACK_EN
  assign sin = loopback ? mosi : miso;
`else
  assign sin = miso;
`endif

  // cpha=0 presents bit 0 at accept, so the trailing edge after the last sample must not shift.
  assign drive_evt  = mode_q.cpha ? lead : (trail && !last_half);
  assign sample_evt = mode_q.cpha ? trail : lead;

  always_comb begin
    sh_src = (state == IDLE) ? tx_data : tx_sh;
    if (MSB_FIRST != 0) begin
      sh_bit  = sh_src[DATA_W-1];
      sh_next = {sh_src[DATA_W-2:0], 1'b0};
      rx_next = {rx_sh[DATA_W-2:0], sin};
    end else begin
      sh_bit  = sh_src[0];
      sh_next = {1'b0, sh_src[DATA_W-1:1]};
      rx_next = {sin, rx_sh[DATA_W-1:1]};
    end
  end

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (busy),
    .load      (accept),
    .load_lvl  (cpol),
    .idle_lvl  (mode_q.cpol),
    .toggle_en (state == XFER),
    .tick      (tick),
    .sclk      (sclk),
    .lead      (lead),
    .trail     (trail)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mode_q   <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      half_cnt <= '0;
      mosi     <= 1'b0;
      ss_n     <= 1'b1;
      busy     <= 1'b0;
      tx_ready <= 1'b1;
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      rx_valid <= 1'b0;
      if (sample_evt) rx_sh <= rx_next;
      if (drive_evt) begin
        mosi  <= sh_bit;
        tx_sh <= sh_next;
      end
      case (state)
        IDLE: if (accept) begin
          mode_q.cpol <= cpol;
          mode_q.cpha <= cpha;
          half_cnt    <= '0;
          ss_n        <= 1'b0;
          busy        <= 1'b1;
          tx_ready    <= 1'b0;
          state       <= SETUP;
          if (!cpha) begin
            mosi  <= sh_bit;
            tx_sh <= sh_next;
          end else begin
            tx_sh <= tx_data;
          end
        end
        SETUP: if (tick) state <= XFER;
        XFER: if (tick) begin
          half_cnt <= half_cnt + BIT_W'(1);
          if (last_half) state <= HOLD;
        end
        HOLD: if (tick) begin
          state    <= IDLE;
          ss_n     <= 1'b1;
          busy     <= 1'b0;
          tx_ready <= 1'b1;
          rx_valid <= 1'b1;
          rx_data  <= rx_sh;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_modes.sv
// Directed bench for spi_master_modes: default 8-bit instance with a mode-aware slave model,
// plus a 16-bit LSB-first CLK_DIV=1 instance whose sample path is fed from its own mosi.
module tb_spi_master_modes;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        tx_valid, tx_ready, cpol, cpha, miso, sclk, mosi, ss_n, busy, rx_valid;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid2, tx_ready2, cpol2, cpha2, miso2, sclk2, mosi2, ss_n2, busy2, rx_valid2;
  logic [15:0] tx_data2, rx_data2;

  int errors = 0;
  int checks = 0;

`ifdef SPI_LOOPBACK_EN
  logic loopback, loopback2;
  assign loopback  = 1'b0;
  assign loopback2 = 1'b1;
  assign miso2     = ~mosi2;  // must be ignored while loopback2=1
`else
  assign miso2     = mosi2;
`endif

  spi_master_modes dut (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .cpol(cpol), .cpha(cpha), .miso(miso),
`ifdef SPI_LOOPBACK_EN
    .loopback(loopback),
`endif
    .sclk(sclk), .mosi(mosi), .ss_n(ss_n), .busy(busy), .rx_valid(rx_valid), .rx_data(rx_data)
  );

  spi_master_modes #(.DATA_W(16), .CLK_DIV(1), .MSB_FIRST(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid2), .tx_ready(tx_ready2), .tx_data(tx_data2),
    .cpol(cpol2), .cpha(cpha2), .miso(miso2),
`ifdef SPI_LOOPBACK_EN
    .loopback(loopback2),
`endif
    .sclk(sclk2), .mosi(mosi2), .ss_n(ss_n2), .busy(busy2), .rx_valid(rx_valid2), .rx_data(rx_data2)
  );

  // Slave model and link monitor, evaluated on the falling clk edge.
  logic [7:0] s_word = 8'h00, l_word = 8'h00, cap = 8'h00, rx_last = 8'h00;
  logic       s_cpol = 1'b0, s_cpha = 1'b0, l_cpol = 1'b0, l_cpha = 1'b0;
  logic       p_ss = 1'b1, p_sclk = 1'b0, p_mosi = 1'b0;
  int low_run = 0, last_low = 0, high_run = 0, last_gap = 0;
  int rx_cnt = 0, s_cnt = 0, cap_n = 0, mosi_nonfall = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      miso = 1'b0; low_run = 0; p_ss = 1'b1; p_sclk = sclk; p_mosi = mosi;
    end else begin
      if (ss_n) begin
        if (!p_ss) last_low = low_run;
        high_run = p_ss ? high_run + 1 : 1;
      end else if (p_ss) begin
        last_gap = high_run; low_run = 1;
        l_word = s_word; l_cpol = s_cpol; l_cpha = s_cpha;
        s_cnt = 0; cap = 8'h00; cap_n = 0; mosi_nonfall = 0;
        if (!l_cpha) miso = l_word[7];
      end else begin
        low_run++;
        if (sclk != p_sclk) begin
          if (p_sclk == l_cpol) begin
            if (l_cpha) begin
              if (s_cnt < 8) miso = l_word[7 - s_cnt];
              s_cnt++;
            end else begin
              cap = {cap[6:0], mosi}; cap_n++;
            end
          end else begin
            if (l_cpha) begin
              cap = {cap[6:0], mosi}; cap_n++;
            end else begin
              s_cnt++;
              if (s_cnt < 8) miso = l_word[7 - s_cnt];
            end
          end
        end
        if (mosi != p_mosi && !(p_sclk && !sclk)) mosi_nonfall++;
      end
      if (rx_valid) begin rx_cnt++; rx_last = rx_data; end
      p_ss = ss_n; p_sclk = sclk; p_mosi = mosi;
    end
  end

  task automatic wait_rx(input int budget, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk); #1;
      if (rx_valid) seen = 1'b1;
    end
  endtask

  task automatic start_xfer(input logic [7:0] d, input logic p, input logic h, input logic [7:0] sw);
    @(negedge clk);
    s_word = sw; s_cpol = p; s_cpha = h;
    tx_data = d; cpol = p; cpha = h; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0; tx_data = ~d; cpol = ~p; cpha = ~h;
    #1;
  endtask

  task automatic test_reset;
    int bad;
    rst_n = 1'b0;
    tx_valid = 1'b0; tx_data = 8'h00; cpol = 1'b0; cpha = 1'b0;
    tx_valid2 = 1'b0; tx_data2 = 16'h0000; cpol2 = 1'b0; cpha2 = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (sclk !== 1'b0 || mosi !== 1'b0 || ss_n !== 1'b1 || busy !== 1'b0 ||
        tx_ready !== 1'b1 || rx_valid !== 1'b0 || rx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_values: sclk=%b mosi=%b ss_n=%b busy=%b tx_ready=%b rx_valid=%b rx_data=%h, want 0 0 1 0 1 0 00",
               sclk, mosi, ss_n, busy, tx_ready, rx_valid, rx_data);
    end
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (sclk !== 1'b0 || ss_n !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0 || rx_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || rx_cnt != 0) begin
      errors++;
      $display("FAIL idle_after_reset: %0d bad idle cycles, %0d rx_valid pulses, want 0 and 0", bad, rx_cnt);
    end
  endtask

  task automatic test_mode0;
    logic seen;
    int   rx0;
    rx0 = rx_cnt;
    start_xfer(8'h3C, 1'b0, 1'b0, 8'hA5);
    checks++;
    if (ss_n !== 1'b0 || tx_ready !== 1'b0 || busy !== 1'b1 || sclk !== 1'b0) begin
      errors++;
      $display("FAIL mode0_accept: ss_n=%b tx_ready=%b busy=%b sclk=%b, want 0 0 1 0", ss_n, tx_ready, busy, sclk);
    end
    wait_rx(100, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL mode0_rx_timeout: no rx_valid within 100 cycles"); end
    checks++;
    if (rx_data !== 8'hA5) begin errors++; $display("FAIL mode0_rx_data: got %h want a5", rx_data); end
    checks++;
    if (cap !== 8'h3C || cap_n != 8) begin
      errors++; $display("FAIL mode0_mosi: got %h (%0d bits) want 3c (8 bits)", cap, cap_n);
    end
    checks++;
    if (last_low != 36) begin errors++; $display("FAIL mode0_ss_len: got %0d want 36", last_low); end
    checks++;
    if (ss_n !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL mode0_done: ss_n=%b tx_ready=%b busy=%b, want 1 1 0", ss_n, tx_ready, busy);
    end
    @(negedge clk); #1;
    checks++;
    if (rx_valid !== 1'b0 || rx_cnt - rx0 != 1 || rx_data !== 8'hA5 || sclk !== 1'b0) begin
      errors++;
      $display("FAIL mode0_after: rx_valid=%b pulses=%0d rx_data=%h sclk=%b, want 0 1 a5 0",
               rx_valid, rx_cnt - rx0, rx_data, sclk);
    end
  endtask

  task automatic test_mode3;
    logic seen;
    start_xfer(8'hF0, 1'b1, 1'b1, 8'h0F);
    checks++;
    if (sclk !== 1'b1) begin errors++; $display("FAIL mode3_idle_high: sclk=%b want 1", sclk); end
    wait_rx(100, seen);
    checks++;
    if (!seen || rx_data !== 8'h0F) begin
      errors++; $display("FAIL mode3_rx_data: seen=%b got %h want 0f", seen, rx_data);
    end
    checks++;
    if (cap !== 8'hF0 || cap_n != 8 || mosi_nonfall != 0) begin
      errors++;
      $display("FAIL mode3_mosi: got %h (%0d bits, %0d non-falling changes) want f0 (8 bits, 0)", cap, cap_n, mosi_nonfall);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (sclk !== 1'b1 || last_low != 36) begin
      errors++; $display("FAIL mode3_end: sclk=%b ss_len=%0d want 1 36", sclk, last_low);
    end
  endtask

  task automatic test_back_to_back;
    logic seen;
    @(negedge clk);
    s_word = 8'h81; s_cpol = 1'b0; s_cpha = 1'b1;
    tx_data = 8'h01; cpol = 1'b0; cpha = 1'b1; tx_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk); #1;
      if (!ss_n) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL b2b_first_accept: ss_n never fell"); end
    tx_data = 8'h02; cpha = 1'b0;
    s_word = 8'h42; s_cpha = 1'b0;
    wait_rx(100, seen);
    checks++;
    if (!seen || rx_data !== 8'h81 || cap !== 8'h01 || last_low != 36) begin
      errors++;
      $display("FAIL b2b_first: seen=%b rx=%h mosi=%h ss_len=%0d want 1 81 01 36", seen, rx_data, cap, last_low);
    end
    @(negedge clk); #1;
    tx_valid = 1'b0;
    checks++;
    if (ss_n !== 1'b0 || tx_ready !== 1'b0 || last_gap < 1) begin
      errors++;
      $display("FAIL b2b_second_accept: ss_n=%b tx_ready=%b gap=%0d want 0 0 >=1", ss_n, tx_ready, last_gap);
    end
    wait_rx(100, seen);
    checks++;
    if (!seen || rx_data !== 8'h42 || cap !== 8'h02 || cap_n != 8 || last_low != 36) begin
      errors++;
      $display("FAIL b2b_second: seen=%b rx=%h mosi=%h bits=%0d ss_len=%0d want 1 42 02 8 36",
               seen, rx_data, cap, cap_n, last_low);
    end
  endtask

  task automatic test_reset_mid;
    logic seen;
    int   rx0;
    start_xfer(8'hAA, 1'b1, 1'b0, 8'h55);
    for (int i = 0; i < 100 && cap_n < 4; i++) begin @(negedge clk); #1; end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (cap_n != 4 || sclk !== 1'b1 || mosi !== 1'b1 || ss_n !== 1'b0) begin
      errors++;
      $display("FAIL mid_pre_reset: bits=%0d sclk=%b mosi=%b ss_n=%b want 4 1 1 0", cap_n, sclk, mosi, ss_n);
    end
    rx0 = rx_cnt;
    rst_n = 1'b0;
    #1;
    checks++;
    if (sclk !== 1'b0 || mosi !== 1'b0 || ss_n !== 1'b1 || busy !== 1'b0 ||
        tx_ready !== 1'b1 || rx_valid !== 1'b0 || rx_data !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_values: sclk=%b mosi=%b ss_n=%b busy=%b tx_ready=%b rx_valid=%b rx_data=%h, want 0 0 1 0 1 0 00",
               sclk, mosi, ss_n, busy, tx_ready, rx_valid, rx_data);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    #1;
    checks++;
    if (rx_cnt != rx0 || sclk !== 1'b0 || ss_n !== 1'b1) begin
      errors++;
      $display("FAIL mid_no_rx: pulses=%0d sclk=%b ss_n=%b want 0 0 1", rx_cnt - rx0, sclk, ss_n);
    end
    start_xfer(8'hC3, 1'b0, 1'b0, 8'h96);
    wait_rx(100, seen);
    checks++;
    if (!seen || rx_data !== 8'h96 || cap !== 8'hC3 || last_low != 36) begin
      errors++;
      $display("FAIL mid_recover: seen=%b rx=%h mosi=%h ss_len=%0d want 1 96 c3 36", seen, rx_data, cap, last_low);
    end
  endtask

  task automatic test_loopback16;
    logic seen;
    int   n;
    @(negedge clk);
    tx_data2 = 16'hBEEF; cpol2 = 1'b0; cpha2 = 1'b0; tx_valid2 = 1'b1;
    @(negedge clk);
    tx_valid2 = 1'b0; tx_data2 = 16'h0000;
    n = 0; seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      #1;
      if (rx_valid2) seen = 1'b1;
      else begin
        if (!ss_n2) n++;
        @(negedge clk);
      end
    end
    checks++;
    if (!seen || rx_data2 !== 16'hBEEF) begin
      errors++; $display("FAIL loop16_rx_data: seen=%b got %h want beef", seen, rx_data2);
    end
    checks++;
    if (n != 34) begin errors++; $display("FAIL loop16_ss_len: got %0d want 34", n); end
    checks++;
    if (ss_n2 !== 1'b1 || tx_ready2 !== 1'b1 || busy2 !== 1'b0 || sclk2 !== 1'b0) begin
      errors++;
      $display("FAIL loop16_done: ss_n=%b tx_ready=%b busy=%b sclk=%b want 1 1 0 0", ss_n2, tx_ready2, busy2, sclk2);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_mode0();
    test_mode3();
    test_back_to_back();
    test_reset_mid();
    test_loopback16();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_master_modes.md
Name: spi_master_modes

Overview:
- Parametrised SPI master. Successor to the fixed-mode 8-bit SPI transmitter.
- Supports all four SPI modes (CPOL/CPHA, selected per transaction), configurable word width and SCLK divider.
- Full-duplex: shifts tx_data out on mosi and captures miso into rx_data.
- Sits between a local valid/ready command source and an external SPI slave.

Parameters:
- DATA_W, 8: bits per transaction; legal range 2..32.
- CLK_DIV, 2: clk cycles per SCLK half-period; must be >= 1.
- MSB_FIRST, 1: 1 = MSB shifted first; 0 = LSB first.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- tx_valid  in  1  request a transaction.
- tx_ready  out  1  high only in IDLE; transfer accepted when tx_valid && tx_ready at a rising clk edge.
- tx_data  in  DATA_W  word to send; sampled at accept.
- cpol  in  1  SCLK idle level; sampled at accept.
- cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; sampled at accept.
- miso  in  1  serial data from slave.
- sclk  out  1  SPI clock.
- mosi  out  1  serial data to slave.
- ss_n  out  1  active-low slave select.
- busy  out  1  high in any state other than IDLE.
- rx_valid  out  1  one-cycle pulse when rx_data is updated.
- rx_data  out  DATA_W  last received word; held until the next rx_valid.

Behaviour:
Reset values (asynchronous, immediate):
- sclk=0, mosi=0, ss_n=1, busy=0, tx_ready=1, rx_valid=0, rx_data=0.
- State = IDLE; divider and bit counters cleared.

Reset mid-transfer:
- Aborts the transfer immediately with the reset values above.
- No rx_valid is generated.
- After reset release, sclk idles at 0 until the next accept latches a new cpol.

State machine (IDLE, SETUP, XFER, HOLD):
- IDLE: sclk = latched cpol.
  - On accept: latch tx_data, cpol and cpha, then go to SETUP.
  - ss_n goes low on the cycle after the accept edge.
- SETUP: lasts CLK_DIV cycles with sclk idle.
  - If cpha=0, the first bit is on mosi at SETUP entry.
- XFER: 2*DATA_W half-periods of CLK_DIV cycles each. sclk toggles at each half-period boundary.
  - cpha=0: sample miso on leading edges; shift mosi on trailing edges, except after the last bit.
  - cpha=1: drive the next bit on leading edges; sample miso on trailing edges.
  - The final sclk edge returns sclk to its idle level.
- HOLD: lasts CLK_DIV cycles with sclk idle. Then go to IDLE.
  - In the cycle IDLE is entered: ss_n=1, rx_valid=1, rx_data = captured word.

Timing:
- ss_n low for exactly (2*DATA_W+2)*CLK_DIV cycles. Defaults: 36 cycles.
- tx_ready is low from the accept edge until IDLE is re-entered.
- Back-to-back transfers: ss_n stays high for at least 1 cycle between transactions.
- tx_valid is ignored while busy. Changes on tx_data/cpol/cpha after accept have no effect.

Counters:
- Divider counter width is $clog2(CLK_DIV)+1 bits and wraps at CLK_DIV-1.
- Bit counter width is $clog2(2*DATA_W)+1 bits.
- No arithmetic overflow for any legal parameter value.

Bit ordering:
- MSB_FIRST=1: bit DATA_W-1 is first on mosi; received bits fill rx_data from the MSB down.
- MSB_FIRST=0: mirror of the above.

Optional Feature:
- Macro: SPI_LOOPBACK_EN.
- Defined: adds input port loopback (1 bit). When loopback=1, the internal sample path takes mosi instead of miso, and the external miso is ignored. Pins and timing are unchanged.
- Undefined: no loopback port; the sample path is always miso.

Decomposition:
- Package spi_pkg:
  - state enum spi_state_t {IDLE, SETUP, XFER, HOLD};
  - struct spi_mode_t {cpol, cpha};
  - localparam functions for counter widths.
- One sub-module, spi_sclk_gen: divider counter, half-period tick, sclk toggling and leading/trailing edge strobes. Parametrised by CLK_DIV.
- Shift/sample logic and the FSM stay in spi_master_modes.

Test Plan:
- Reset then idle: hold rst_n=0 for 5 cycles, then release -> sclk=0, ss_n=1, tx_ready=1, no rx_valid for 50 cycles.
- Mode 0, defaults, slave model echoing 8'hA5 on miso, tx_data=8'h3C -> mosi bit sequence 0,0,1,1,1,1,0,0; ss_n low for 36 cycles; rx_valid with rx_data=8'hA5.
- Mode 3 (cpol=1, cpha=1), tx_data=8'hF0, slave returns 8'h0F -> sclk idles high; mosi changes on falling edges; rx_data=8'h0F.
- Back-to-back: tx_valid held high with 8'h01 then 8'h02 in mode 1 -> two accepts; ss_n high for at least 1 cycle between transfers; second transfer's cpha/data are latched independently.
- Reset mid-transfer: assert rst_n=0 at bit 4 of a mode 2 transfer -> outputs go to reset values in the same cycle; no rx_valid; the next transfer completes correctly.
- DATA_W=16, CLK_DIV=1, MSB_FIRST=0, loopback=1 (SPI_LOOPBACK_EN defined), tx_data=16'hBEEF -> rx_data=16'hBEEF; ss_n low for 34 cycles.
